// File: rtl/glove_pkg.sv
// glove_pkg: shared constants, Q8.8 word, Conv window array and normalizer FSM states
package glove_pkg;
    localparam int N_CH = 8;
    localparam int WIN  = 5;
    localparam int DW   = 16;
    localparam int FRAC = 8;
    localparam int QW   = DW + FRAC;

    typedef logic signed [DW-1:0] word_t;
    typedef word_t window_t [N_CH*WIN];
    typedef enum logic [2:0] {IDLE, LOAD, DIV, STORE, SHIFT} state_t;

    localparam word_t Q_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam word_t Q_MIN = {1'b1, {(DW-1){1'b0}}};
endpackage

// File: rtl/fx_serial_div.sv
// fx_serial_div: restoring unsigned divider, one quotient bit per cycle MSB first, QW cycles
// from start to done; division by zero yields a zero quotient.
module fx_serial_div
    import glove_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          start,
    input  logic [QW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [QW-1:0] quotient
);
    localparam int CNTW = $clog2(QW);

    logic [DW-1:0]   rem, dvs, rem_in, dvs_in, rem_nx;
    logic [QW-1:0]   quo, quo_in;
    logic [CNTW-1:0] cnt;
    logic [DW:0]     trial;
    logic            ge;

    // the start cycle already performs the first iteration so done lands QW cycles later
    assign rem_in   = start ? '0 : rem;
    assign quo_in   = start ? dividend : quo;
    assign dvs_in   = start ? divisor : dvs;
    assign trial    = {rem_in, quo_in[QW-1]};
    assign ge       = trial >= {1'b0, dvs_in};
    assign rem_nx   = ge ? DW'(trial - {1'b0, dvs_in}) : trial[DW-1:0];
    assign quotient = dvs == '0 ? '0 : quo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
            rem  <= '0;
            quo  <= '0;
            dvs  <= '0;
        end else if (clear) begin
            busy <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (start || busy) begin
                rem <= rem_nx;
                quo <= {quo_in[QW-2:0], ge};
                cnt <= start ? CNTW'(QW-1) : cnt - 1'b1;
            end
            if (start) begin
                dvs  <= divisor;
                busy <= 1'b1;
            end else if (busy && cnt == CNTW'(1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/norm_window.sv
// norm_window: normalizes a frame of signed samples to Q8.8 ((sample-mean)/std) with one shared
// serial divider, and keeps a sliding window of the last WIN frames per channel for Conv.
module norm_window
    import glove_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_valid,
    output logic          o_ready,
    input  word_t         i_sample [N_CH],
    input  word_t         i_mean   [N_CH],
    input  logic [DW-1:0] i_std    [N_CH],
    input  logic          i_clear,
    output window_t       o_data,
    output logic          o_valid
);
    localparam int CW = $clog2(N_CH);
    localparam int FW = $clog2(WIN + 1);

    state_t        state, nxt;
    logic [CW-1:0] ch;
    logic [FW-1:0] fill;
    word_t         smp [N_CH], mn [N_CH], stage [N_CH];
    logic [DW-1:0] sd [N_CH];
    logic signed [DW:0] diff;
    logic [DW-1:0] mag;
    logic          neg, last_ch, sat;
    logic          div_busy, div_done;
    logic [QW-1:0] quo;
    word_t         res;

    assign o_ready = state == IDLE;
    assign last_ch = ch == CW'(N_CH - 1);
    assign diff    = {smp[ch][DW-1], smp[ch]} - {mn[ch][DW-1], mn[ch]};
    assign mag     = diff[DW] ? DW'(-diff) : diff[DW-1:0];
    // any quotient of 2^(DW-1) or more is out of range for either sign
    assign sat     = |quo[QW-1:DW-1];
    assign res     = sat ? (neg ? Q_MIN : Q_MAX) : word_t'(neg ? -quo[DW-1:0] : quo[DW-1:0]);

    fx_serial_div u_div (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .clear    (i_clear),
        .start    (state == LOAD && !div_busy),
        .dividend ({mag, {FRAC{1'b0}}}),
        .divisor  (sd[ch]),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quo)
    );

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    nxt = i_valid ? LOAD : IDLE;
            LOAD:    nxt = DIV;
            DIV:     nxt = div_done ? STORE : DIV;
            STORE:   nxt = last_ch ? SHIFT : LOAD;
            SHIFT:   nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= IDLE;
        else
            state <= i_clear ? IDLE : nxt;
    end

    always_ff @(posedge i_clk) begin
        if (o_ready && i_valid && !i_clear) begin
            smp <= i_sample;
            mn  <= i_mean;
            sd  <= i_std;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ch      <= '0;
            fill    <= '0;
            neg     <= 1'b0;
            o_valid <= 1'b0;
            o_data  <= '{default: '0};
            stage   <= '{default: '0};
        end else if (i_clear) begin
            ch      <= '0;
            fill    <= '0;
            neg     <= 1'b0;
            o_valid <= 1'b0;
            o_data  <= '{default: '0};
            stage   <= '{default: '0};
        end else begin
            o_valid <= 1'b0;
            if (state == LOAD)
                neg <= diff[DW];
            if (state == STORE) begin
                stage[ch] <= res;
                ch        <= last_ch ? '0 : ch + 1'b1;
            end
            if (state == SHIFT) begin
                for (int c = 0; c < N_CH; c++) begin
                    for (int t = 0; t < WIN - 1; t++)
                        o_data[c*WIN+t] <= o_data[c*WIN+t+1];
                    o_data[c*WIN+WIN-1] <= stage[c];
                end
                fill    <= fill == FW'(WIN) ? fill : fill + 1'b1;
                o_valid <= fill >= FW'(WIN - 1);
            end
        end
    end
endmodule

// File: tb/tb_norm_window.sv
// tb_norm_window: table vectors plus hand sequences; expected windows come from a scoreboard
// queue filled at drive time and a bench-side window model updated when each frame completes.
module tb_norm_window;
    import glove_pkg::*;

    logic          clk = 1'b0, rst_n = 1'b0, i_valid = 1'b0, i_clear = 1'b0;
    logic          o_ready, o_valid;
    word_t         i_sample [N_CH], i_mean [N_CH];
    logic [DW-1:0] i_std [N_CH];
    window_t       o_data;

    norm_window dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_sample (i_sample),
        .i_mean   (i_mean),
        .i_std    (i_std),
        .i_clear  (i_clear),
        .o_data   (o_data),
        .o_valid  (o_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        word_t       s;
        word_t       m;
        logic [15:0] d;
        word_t       e;
    } vec_t;

    vec_t          tbl [7];
    int            n_vec = 0, n_err = 0;
    word_t         mdl [N_CH*WIN];
    int            mfill = 0;
    word_t         sbq [$];
    word_t         s_v [N_CH], m_v [N_CH], e_v [N_CH];
    logic [DW-1:0] d_v [N_CH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int win_mis();
        int n = 0;
        for (int i = 0; i < N_CH*WIN; i++)
            if (o_data[i] !== mdl[i]) n++;
        return n;
    endfunction

    function automatic word_t ref_norm(input word_t s, input word_t m, input logic [15:0] d);
        int diff = int'(s) - int'(m);
        int q;
        if (d == 0) return '0;
        q = ((diff < 0 ? -diff : diff) * 256) / int'({16'h0, d});
        if (diff < 0) q = -q;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return word_t'(q);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_CH*WIN; i++) mdl[i] = '0;
        mfill = 0;
        sbq.delete();
    endtask

    task automatic scramble();
        for (int c = 0; c < N_CH; c++) begin
            i_sample[c] = word_t'($urandom);
            i_mean[c]   = word_t'($urandom);
            i_std[c]    = 16'($urandom);
        end
    endtask

    task automatic drive_frame();
        @(negedge clk);
        check("ready_at_drive", o_ready, 1);
        for (int c = 0; c < N_CH; c++) begin
            i_sample[c] = s_v[c];
            i_mean[c]   = m_v[c];
            i_std[c]    = d_v[c];
            sbq.push_back(e_v[c]);
        end
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        scramble();
    endtask

    task automatic run_frame(input bit inject);
        int cyc = 0, bad = 0;
        bit done = 0;
        drive_frame();
        while (!done && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            if (o_ready) done = 1;
            else if (o_valid || win_mis() != 0) bad++;
            i_valid = inject && cyc == 50;
        end
        i_valid = 1'b0;
        check("busy_hold", bad, 0);
        check("latency", cyc, 209);
        if (sbq.size() >= N_CH) begin
            for (int c = 0; c < N_CH; c++) begin
                for (int t = 0; t < WIN - 1; t++) mdl[c*WIN+t] = mdl[c*WIN+t+1];
                mdl[c*WIN+WIN-1] = sbq.pop_front();
            end
            if (mfill < WIN) mfill++;
        end
        check("o_valid", o_valid, mfill == WIN);
        check("window", win_mis(), 0);
    endtask

    task automatic fill_all(input word_t s, input word_t m, input logic [15:0] d, input word_t e);
        for (int c = 0; c < N_CH; c++) begin
            s_v[c] = s;
            m_v[c] = m;
            d_v[c] = d;
            e_v[c] = e;
        end
    endtask

    initial begin
        int bad;
        tbl[0] = '{s: 16'h1000, m: 16'h0F00, d: 16'h0200, e: 16'h0080};
        tbl[1] = '{s: 16'h0E00, m: 16'h0F00, d: 16'h0200, e: 16'hFF80};
        tbl[2] = '{s: 16'h0001, m: 16'h0000, d: 16'h0003, e: 16'h0055};
        tbl[3] = '{s: 16'h0000, m: 16'h0001, d: 16'h0003, e: 16'hFFAB};
        tbl[4] = '{s: 16'h1234, m: 16'h0034, d: 16'h0000, e: 16'h0000};
        tbl[5] = '{s: 16'h7FFF, m: 16'h0000, d: 16'h0001, e: 16'h7FFF};
        tbl[6] = '{s: 16'h8000, m: 16'h7FFF, d: 16'h0001, e: 16'h8000};
        scramble();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", win_mis(), 0);
        check("reset_valid", o_valid, 0);
        check("reset_ready", o_ready, 1);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            fill_all(tbl[i].s, tbl[i].m, tbl[i].d, tbl[i].e);
            run_frame(0);
            check("newest_ch0", o_data[WIN-1], tbl[i].e);
        end

        for (int c = 0; c < N_CH; c++) begin
            s_v[c] = word_t'($urandom);
            m_v[c] = word_t'($urandom_range(0, 8191));
            d_v[c] = 16'($urandom_range(1, 40));
            e_v[c] = ref_norm(s_v[c], m_v[c], d_v[c]);
        end
        run_frame(1);

        fill_all(16'h1000, 16'h0F00, 16'h0200, 16'h0080);
        drive_frame();
        repeat (99) @(posedge clk);
        #1;
        i_clear = 1'b1;
        @(posedge clk);
        #1;
        i_clear = 1'b0;
        model_reset();
        check("clear_data", win_mis(), 0);
        check("clear_ready", o_ready, 1);
        check("clear_valid", o_valid, 0);

        @(negedge clk);
        i_valid = 1'b1;
        i_clear = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_clear = 1'b0;
        bad = 0;
        repeat (230) begin
            @(posedge clk);
            #1;
            if (!o_ready || o_valid || win_mis() != 0) bad++;
        end
        check("clear_drops_frame", bad, 0);

        for (int k = 1; k <= 6; k++) begin
            fill_all(word_t'(k * 256), 16'h0000, 16'h0100, word_t'(k * 256));
            run_frame(0);
        end
        for (int c = 0; c < N_CH; c++)
            for (int t = 0; t < WIN; t++)
                check("fill_window", o_data[c*WIN+t], word_t'((t + 2) << 8));

        for (int f = 0; f < 4; f++) begin
            for (int c = 0; c < N_CH; c++) begin
                s_v[c] = word_t'($urandom);
                m_v[c] = word_t'($urandom);
                d_v[c] = (c % 2 == 1) ? 16'($urandom_range(0, 20)) : 16'($urandom);
                e_v[c] = ref_norm(s_v[c], m_v[c], d_v[c]);
            end
            run_frame(0);
        end

        drive_frame();
        repeat (60) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midreset_data", win_mis(), 0);
        check("midreset_ready", o_ready, 1);
        check("midreset_valid", o_valid, 0);
        #1;
        rst_n = 1'b1;
        fill_all(16'h0300, 16'h0100, 16'h0100, 16'h0200);
        run_frame(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
